// File: rtl/generic_cells_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : generic_cells_pkg
//  Description : Shared types and constants for the generic_cells library.
//  Revision    : 1.0 - initial release
// ============================================================================
package generic_cells_pkg;

    typedef enum logic [1:0] {
        DC_IDLE = 2'd0,
        DC_RUN  = 2'd1,
        DC_DONE = 2'd2
    } dc_state_t;

    localparam logic DC_ONESHOT = 1'b0;
    localparam logic DC_RELOAD  = 1'b1;

endpackage : generic_cells_pkg
`default_nettype wire

// File: rtl/down_counter.sv
`default_nettype none
// ============================================================================
//  Module      : down_counter
//  Description : Loadable down counter / tick timer with borrow (underflow)
//                pulse, one-shot and auto-reload modes.
//  Revision    : 1.0 - initial release
// ============================================================================
module down_counter
    import generic_cells_pkg::*;
#(
    parameter int DECREMENT_RATE = 1,
    parameter int WIDTH          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             mode,
    output logic [WIDTH-1:0] count_val,
    output logic             underflow,
    output logic             zero,
    output logic             busy
);

    localparam logic [WIDTH:0] c_rate = (WIDTH+1)'(DECREMENT_RATE);

    generate
        if (WIDTH < 2 || DECREMENT_RATE < 1 ||
            longint'(DECREMENT_RATE) > ((longint'(1) << WIDTH) - 1)) begin : g_param_check
            $error("down_counter: illegal WIDTH/DECREMENT_RATE combination");
        end
    endgenerate

    dc_state_t        r_state;
    dc_state_t        w_state_nxt;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;
    logic [WIDTH-1:0] r_reload;
    logic [WIDTH-1:0] w_reload_nxt;
    logic             r_underflow;
    logic             w_underflow_nxt;
    logic [WIDTH:0]   w_nxt;
    logic             w_borrow;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= DC_IDLE;
            r_count     <= '0;
            r_reload    <= '0;
            r_underflow <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_count     <= w_count_nxt;
            r_reload    <= w_reload_nxt;
            r_underflow <= w_underflow_nxt;
        end
    end

    // Next-state logic; the extra MSB of w_nxt is the borrow out
    always_comb begin
        w_nxt           = {1'b0, r_count} - c_rate;
        w_borrow        = w_nxt[WIDTH];
        w_state_nxt     = r_state;
        w_count_nxt     = r_count;
        w_reload_nxt    = r_reload;
        w_underflow_nxt = 1'b0;

        if (clear) begin
            w_state_nxt = DC_IDLE;
            w_count_nxt = '0;
        end else if (load) begin
            w_count_nxt  = load_val;
            w_reload_nxt = load_val;
            w_state_nxt  = (load_val != '0) ? DC_RUN : DC_DONE;
        end else if (r_state == DC_RUN && en) begin
            if (!w_borrow) begin
                w_count_nxt = w_nxt[WIDTH-1:0];
            end else if (mode == DC_ONESHOT) begin
                w_underflow_nxt = 1'b1;
                w_count_nxt     = '0;
                w_state_nxt     = DC_DONE;
            end else begin
                // A zero reload would spin forever at 0; stop instead
                w_underflow_nxt = 1'b1;
                w_count_nxt     = r_reload;
                w_state_nxt     = (r_reload == '0) ? DC_DONE : DC_RUN;
            end
        end
    end

    // Outputs
    always_comb begin
        count_val = r_count;
        underflow = r_underflow;
        zero      = (r_count == '0);
        busy      = (r_state == DC_RUN);
    end

endmodule : down_counter
`default_nettype wire

// File: tb/tb_down_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_down_counter
//  Description : Directed self-checking bench for down_counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_down_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       clear;
    logic       load;
    logic       mode;
    logic [7:0] load_val;
    logic [3:0] load_val_b;

    logic [7:0] count_a;
    logic       uf_a, zero_a, busy_a;
    logic [3:0] count_b;
    logic       uf_b, zero_b, busy_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    down_counter #(.DECREMENT_RATE(1), .WIDTH(8)) u_dut_a (
        .clk(clk), .rst(rst), .en(en), .clear(clear), .load(load),
        .load_val(load_val), .mode(mode), .count_val(count_a),
        .underflow(uf_a), .zero(zero_a), .busy(busy_a)
    );

    down_counter #(.DECREMENT_RATE(3), .WIDTH(4)) u_dut_b (
        .clk(clk), .rst(rst), .en(en), .clear(clear), .load(load),
        .load_val(load_val_b), .mode(mode), .count_val(count_b),
        .underflow(uf_b), .zero(zero_b), .busy(busy_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check count, underflow, zero, busy of the 8-bit instance
    task automatic check_a(input string tag, input int cnt, input logic uf, input logic bz);
        check({tag, ".count"}, 32'(count_a), 32'(cnt));
        check({tag, ".uf"},    32'(uf_a),    32'(uf));
        check({tag, ".zero"},  32'(zero_a),  32'(cnt == 0));
        check({tag, ".busy"},  32'(busy_a),  32'(bz));
    endtask

    int exp_ar[6] = '{1, 0, 2, 1, 0, 2};
    int exp_uf[6] = '{0, 0, 1, 0, 0, 1};

    initial begin
        rst = 1'b1; en = 1'b0; clear = 1'b0; load = 1'b0; mode = 1'b0;
        load_val = 8'd0; load_val_b = 4'd0;
        step(); step();
        check_a("por", 0, 1'b0, 1'b0);

        // Reset during RUN
        rst = 1'b0; load = 1'b1; load_val = 8'd5;
        step(); load = 1'b0;
        check_a("rst.load", 5, 1'b0, 1'b1);
        en = 1'b1; step();
        check_a("rst.dec", 4, 1'b0, 1'b1);
        rst = 1'b1; step(); step();
        check_a("rst.run", 0, 1'b0, 1'b0);
        rst = 1'b0; step();
        check_a("rst.en_ignored", 0, 1'b0, 1'b0);

        // One-shot, load 3 with en held: load edge does not decrement
        load = 1'b1; load_val = 8'd3; mode = 1'b0;
        step(); load = 1'b0;
        check_a("os.3", 3, 1'b0, 1'b1);
        step(); check_a("os.2", 2, 1'b0, 1'b1);
        step(); check_a("os.1", 1, 1'b0, 1'b1);
        step(); check_a("os.0", 0, 1'b0, 1'b1);
        step(); check_a("os.borrow", 0, 1'b1, 1'b0);
        step(); check_a("os.done", 0, 1'b0, 1'b0);

        // Auto-reload, load 2: period of 3 enabled cycles
        load = 1'b1; load_val = 8'd2; mode = 1'b1;
        step(); load = 1'b0;
        check_a("ar.load", 2, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step();
            check_a($sformatf("ar.%0d", i), exp_ar[i], exp_uf[i][0], 1'b1);
        end

        // W=4, R=3, load 7, one-shot: 7, 4, 1, borrow
        mode = 1'b0; load = 1'b1; load_val_b = 4'd7;
        step(); load = 1'b0;
        check("b.7", 32'(count_b), 32'd7);
        step(); check("b.4", 32'(count_b), 32'd4);
        step(); check("b.1", 32'(count_b), 32'd1);
        check("b.1.uf", 32'(uf_b), 32'd0);
        step(); check("b.borrow.count", 32'(count_b), 32'd0);
        check("b.borrow.uf", 32'(uf_b), 32'd1);
        check("b.borrow.busy", 32'(busy_b), 32'd0);
        check("b.borrow.zero", 32'(zero_b), 32'd1);

        // Priority: clear beats load and en
        load = 1'b1; load_val = 8'd9;
        step();
        check_a("pr.load9", 9, 1'b0, 1'b1);
        clear = 1'b1; load = 1'b1; load_val = 8'd6;
        step(); clear = 1'b0;
        check_a("pr.clear", 0, 1'b0, 1'b0);
        step(); load = 1'b0;
        check_a("pr.load_en", 6, 1'b0, 1'b1);
        load = 1'b1; load_val = 8'd0;
        step(); load = 1'b0;
        check_a("pr.load0", 0, 1'b0, 1'b0);
        step();
        check_a("pr.load0.hold", 0, 1'b0, 1'b0);

        // en toggling 1010 in RUN
        en = 1'b0; load = 1'b1; load_val = 8'd5;
        step(); load = 1'b0;
        check_a("tg.load", 5, 1'b0, 1'b1);
        en = 1'b1; step(); check_a("tg.e1", 4, 1'b0, 1'b1);
        en = 1'b0; step(); check_a("tg.e0", 4, 1'b0, 1'b1);
        en = 1'b1; step(); check_a("tg.e1b", 3, 1'b0, 1'b1);
        en = 1'b0; step(); check_a("tg.e0b", 3, 1'b0, 1'b1);

        // Reset on the edge that would borrow discards the pulse
        load = 1'b1; load_val = 8'd1;
        step(); load = 1'b0;
        en = 1'b1; step();
        check_a("rb.0", 0, 1'b0, 1'b1);
        rst = 1'b1; step();
        check_a("rb.rst", 0, 1'b0, 1'b0);
        rst = 1'b0; en = 1'b0; step();
        check_a("rb.after", 0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_down_counter
`default_nettype wire
